ftdi_scheduler: RTL
===================

FTDI_SCHEDULER -- requirements
Module: ftdi_scheduler

Interface
REQ-001 Parameter PKT_BYTES, default 64: bytes per outbound laser packet, range 2..512.
REQ-002 Parameter QUANTUM, default 256: maximum consecutive clock cycles of one FTDI direction grant.
REQ-003 Ports (name  direction  width  meaning): clock  in  1  sole clock; reset_n  in  1  synchronous, active-low reset.
REQ-004 enable  in  1  scheduler run; flush  in  1  one-cycle request to clear both FTDI queues.
REQ-005 rxf, txe  in  1 each  FTDI chip status, active-low; rdq_empty, rdq_full, wrq_empty, wrq_full  in  1 each  FTDI interface queue flags; qsize  in  10  read-queue occupancy.
REQ-006 rd_en, wr_en, clear  out  1 each  controls to FTDI interface; rdreq  out  1  read-queue pop; data_rd  in  8  read-queue data, valid the cycle after rdreq.
REQ-007 wrreq  out  1  write-queue push; data_wr  out  8  write-queue data.
REQ-008 tx_data  out  8, tx_valid  out  1, tx_ready  in  1, tx_sop  out  1, tx_eop  out  1: outbound laser byte stream.
REQ-009 rx_data  in  8, rx_valid  in  1, rx_ready  out  1: inbound laser byte stream; pkt_count  out  16  completed outbound packets; busy  out  1  high unless arbiter IDLE and packetizer P_IDLE.

Function
REQ-010 Arbiter FSM states IDLE, GRANT_RD, GRANT_WR, FLUSH; rd_en=1 only in GRANT_RD, wr_en=1 only in GRANT_WR, clear=1 only in FLUSH.
REQ-011 Eligibility: rd_ok = !rxf && !rdq_full; wr_ok = !txe && !wrq_empty.
REQ-012 IDLE: flush -> FLUSH (highest priority); else if enable and exactly one of rd_ok/wr_ok -> that grant; if both, grant the direction opposite last_grant (last_grant resets to WR, so first tie grants RD).
REQ-013 Grant states: 10-bit cycle counter cleared on entry; return to IDLE when counter reaches QUANTUM-1, eligibility drops, enable drops, or flush asserts; last_grant updated on entry.
REQ-014 FLUSH: clear held exactly 2 cycles, packetizer forced to P_IDLE, rdreq/wrreq/tx_valid held 0, then IDLE; flush asserted during FLUSH is ignored.
REQ-015 Packetizer FSM P_IDLE, P_FETCH, P_WAIT, P_SEND; byte counter 0..PKT_BYTES-1.
REQ-016 P_IDLE -> P_FETCH only when enable and qsize >= PKT_BYTES, so rdq never underflows mid-packet.
REQ-017 P_FETCH: rdreq=1 for one cycle -> P_WAIT; P_WAIT: latch data_rd into holding register -> P_SEND.
REQ-018 P_SEND: tx_valid=1, tx_data stable until tx_valid && tx_ready; tx_sop=1 at byte 0, tx_eop=1 at byte PKT_BYTES-1.
REQ-019 On accept: not last byte -> P_FETCH, counter+1; last byte -> P_IDLE, counter 0, pkt_count+1 (wraps 65535->0).
REQ-020 enable deasserting mid-packet does not abort: packet completes, then P_IDLE waits.
REQ-021 Inbound: rx_ready = enable && !wrq_full && state!=FLUSH; on rx_valid && rx_ready, wrreq=1 and data_wr=rx_data same cycle (zero latency, combinational).
REQ-022 rdreq never asserted when rdq_empty=1; wrreq never asserted when wrq_full=1.

Reset
REQ-023 reset_n=0 at a clock edge: arbiter IDLE, packetizer P_IDLE, counters, holding register, pkt_count 0, last_grant=WR.
REQ-024 During and after reset until a new decision: rd_en, wr_en, clear, rdreq, wrreq, tx_valid, tx_sop, tx_eop 0; tx_data, data_wr 0; rx_ready 0; busy 0.
REQ-025 Reset mid-packet discards the partial packet; no pkt_count increment.

Configuration
REQ-026 Macro FTDI_SCHED_LOOPBACK_EN defined: tx_valid, tx_sop, tx_eop held 0; rx_ready held 0 and rx_* ignored; P_SEND byte pushed to write queue via wrreq/data_wr when !wrq_full (acts as tx_ready).
REQ-027 Macro undefined: external tx/rx streams as REQ-018..REQ-021; no loopback logic present.

Verification
REQ-028 reset_n=0 for 3 cycles with all inputs active -> every output 0, busy=0.
REQ-029 rxf=0, txe=0, wrq_empty=0, rdq_full=0, enable=1 held -> grants alternate RD,WR,RD, each exactly 256 cycles with 1 IDLE cycle between.
REQ-030 qsize=63 -> no rdreq; qsize=64, tx_ready=1 -> 64 bytes out, sop on first, eop on 64th, pkt_count=1, exactly 64 rdreq pulses.
REQ-031 tx_ready=0 for 10 cycles mid-packet -> tx_data/tx_valid stable, no extra rdreq.
REQ-032 flush during GRANT_RD mid-packet -> clear high exactly 2 cycles, packetizer P_IDLE, pkt_count unchanged.
REQ-033 wrq_full=1 with rx_valid=1 -> rx_ready=0, wrreq=0; in loopback build, 64-byte packet -> 64 wrreq with matching data_wr.

Source files
------------

// File: rtl/ftdi_scheduler.sv
// rtl/ftdi_scheduler.sv - FTDI direction arbiter and laser packetizer; FTDI_SCHED_LOOPBACK_EN routes packets back into the write queue
module ftdi_scheduler #(
    parameter int PKT_BYTES = 64,
    parameter int QUANTUM   = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        rxf,
    input  logic        txe,
    input  logic        rdq_empty,
    input  logic        rdq_full,
    input  logic        wrq_empty,
    input  logic        wrq_full,
    input  logic [9:0]  qsize,
    output logic        rd_en,
    output logic        wr_en,
    output logic        clear,
    output logic        rdreq,
    input  logic [7:0]  data_rd,
    output logic        wrreq,
    output logic [7:0]  data_wr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] pkt_count,
    output logic        busy
);
    localparam int              CW        = $clog2(PKT_BYTES);
    localparam logic [CW-1:0]   LAST_BYTE = CW'(PKT_BYTES - 1);
    localparam logic [9:0]      Q_LAST    = 10'(QUANTUM - 1);
    localparam logic [9:0]      PKT_MIN   = 10'(PKT_BYTES);

    typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR, FLUSH} arb_state_t;
    typedef enum logic [1:0] {P_IDLE, P_FETCH, P_WAIT, P_SEND} pkt_state_t;

    arb_state_t    arb_state;
    pkt_state_t    pkt_state;
    logic [9:0]    grant_cnt;
    logic          last_grant_wr;
    logic [CW-1:0] byte_cnt;
    logic [7:0]    hold_q;
    logic          send_valid;
    logic          send_sop;
    logic          send_eop;
    logic          rd_ok;
    logic          wr_ok;
    logic          flush_hit;
    logic          accept;

    assign rd_ok     = !rxf && !rdq_full;
    assign wr_ok     = !txe && !wrq_empty;
    // A flush taken this edge also kills the packetizer on the same edge,
    // so no pop or send can leak into the first clear cycle.
    assign flush_hit = flush && (arb_state != FLUSH);

`ifdef FTDI_SCHED_LOOPBACK_EN
    assign accept = send_valid && !wrq_full;
`else
    assign accept = send_valid && tx_ready;
`endif

    // Direction arbiter: round-robin grants bounded by QUANTUM, flush has priority
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            arb_state     <= IDLE;
            grant_cnt     <= '0;
            last_grant_wr <= 1'b1;
            rd_en         <= 1'b0;
            wr_en         <= 1'b0;
            clear         <= 1'b0;
        end else begin
            case (arb_state)
                IDLE: begin
                    grant_cnt <= '0;
                    if (flush) begin
                        arb_state <= FLUSH;
                        clear     <= 1'b1;
                    end else if (enable && rd_ok && (!wr_ok || last_grant_wr)) begin
                        arb_state     <= GRANT_RD;
                        rd_en         <= 1'b1;
                        last_grant_wr <= 1'b0;
                    end else if (enable && wr_ok) begin
                        arb_state     <= GRANT_WR;
                        wr_en         <= 1'b1;
                        last_grant_wr <= 1'b1;
                    end
                end
                GRANT_RD, GRANT_WR: begin
                    if (flush) begin
                        arb_state <= FLUSH;
                        grant_cnt <= '0;
                        rd_en     <= 1'b0;
                        wr_en     <= 1'b0;
                        clear     <= 1'b1;
                    end else if (grant_cnt == Q_LAST || !enable ||
                                 ((arb_state == GRANT_RD) ? !rd_ok : !wr_ok)) begin
                        arb_state <= IDLE;
                        grant_cnt <= '0;
                        rd_en     <= 1'b0;
                        wr_en     <= 1'b0;
                    end else begin
                        grant_cnt <= grant_cnt + 10'd1;
                    end
                end
                FLUSH: begin
                    if (grant_cnt == 10'd1) begin
                        arb_state <= IDLE;
                        grant_cnt <= '0;
                        clear     <= 1'b0;
                    end else begin
                        grant_cnt <= grant_cnt + 10'd1;
                    end
                end
                default: arb_state <= IDLE;
            endcase
        end
    end

    // Packetizer: fetch one byte, present it, repeat until a full packet is sent
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pkt_state  <= P_IDLE;
            byte_cnt   <= '0;
            hold_q     <= '0;
            send_valid <= 1'b0;
            send_sop   <= 1'b0;
            send_eop   <= 1'b0;
            pkt_count  <= '0;
        end else if (flush_hit || arb_state == FLUSH) begin
            pkt_state  <= P_IDLE;
            byte_cnt   <= '0;
            send_valid <= 1'b0;
            send_sop   <= 1'b0;
            send_eop   <= 1'b0;
        end else begin
            case (pkt_state)
                P_IDLE: begin
                    if (enable && qsize >= PKT_MIN) pkt_state <= P_FETCH;
                end
                P_FETCH: begin
                    if (!rdq_empty) pkt_state <= P_WAIT;
                end
                P_WAIT: begin
                    hold_q     <= data_rd;
                    send_valid <= 1'b1;
                    send_sop   <= (byte_cnt == '0);
                    send_eop   <= (byte_cnt == LAST_BYTE);
                    pkt_state  <= P_SEND;
                end
                P_SEND: begin
                    if (accept) begin
                        send_valid <= 1'b0;
                        send_sop   <= 1'b0;
                        send_eop   <= 1'b0;
                        if (byte_cnt == LAST_BYTE) begin
                            pkt_state <= P_IDLE;
                            byte_cnt  <= '0;
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            pkt_state <= P_FETCH;
                            byte_cnt  <= byte_cnt + CW'(1);
                        end
                    end
                end
                default: pkt_state <= P_IDLE;
            endcase
        end
    end

    assign rdreq   = (pkt_state == P_FETCH) && !rdq_empty;
    assign tx_data = hold_q;
    assign busy    = !((arb_state == IDLE) && (pkt_state == P_IDLE));

`ifdef FTDI_SCHED_LOOPBACK_EN
    logic unused_lb;
    assign unused_lb = ^{rx_data, rx_valid, tx_ready};
    assign tx_valid  = 1'b0;
    assign tx_sop    = 1'b0;
    assign tx_eop    = 1'b0;
    assign rx_ready  = 1'b0;
    assign wrreq     = accept;
    assign data_wr   = accept ? hold_q : 8'h00;
`else
    assign tx_valid  = send_valid;
    assign tx_sop    = send_sop;
    assign tx_eop    = send_eop;
    assign rx_ready  = reset_n && enable && !wrq_full && (arb_state != FLUSH);
    assign wrreq     = rx_valid && rx_ready;
    assign data_wr   = wrreq ? rx_data : 8'h00;
`endif

endmodule
